// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first, one full-subtractor cell with registered borrow.
// Optional add mode (port op) is enabled by defining SERIAL_SUB_ADD_MODE_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br, w_d, w_br_next, w_sub_next, w_last;
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_sub_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last     = r_cnt == CW'(WIDTH - 1);
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic r_op;
  assign w_br_next = r_op ? ((r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_br)) : w_sub_next;
`else
  assign w_br_next = w_sub_next;
`endif
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign diff      = r_res;
  assign borrow    = r_br;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      r_op    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= 1'b0;
        r_cnt <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        r_op  <= op;
`endif
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= {w_d, r_res[WIDTH-1:1]};
        r_br  <= w_br_next;
        r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor computing `diff = a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart to the team's ripple adder cells. It is meant for area-constrained datapaths where a WIDTH-bit parallel subtractor is not justified. Operands enter through a valid/ready handshake and the result leaves through a second valid/ready handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH >= 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operands `a`/`b` are valid.
- `in_ready` output, 1 bit: block can accept operands. High only in IDLE.
- `a` input, WIDTH bits: minuend, unsigned.
- `b` input, WIDTH bits: subtrahend, unsigned.
- `out_valid` output, 1 bit: `diff`/`borrow` are valid. High only in DONE.
- `out_ready` input, 1 bit: downstream accepts the result.
- `diff` output, WIDTH bits: `(a - b) mod 2^WIDTH`.
- `borrow` output, 1 bit: final borrow-out. 1 if and only if `a < b`.
- `busy` output, 1 bit: high in RUN or DONE.

## Operation
- States:
  - IDLE: reset state.
  - RUN: one result bit is produced per cycle.
  - DONE: the result is held until consumed.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid & in_ready`: capture `a`, `b` into shift registers, clear the borrow register, clear the bit counter, go to RUN.
- RUN, each cycle, with `ai`, `bi` = operand LSBs and `br` = borrow register:
  - Result bit `d = ai ^ bi ^ br`.
  - `br_next = (~ai & bi) | (~(ai ^ bi) & br)`.
  - Operand registers shift right by 1.
  - `d` shifts into the result register MSB, with the result register shifting right.
  - The counter increments.
  - When the counter reaches WIDTH-1 in RUN, that cycle's edge is the final bit: go to DONE.
- DONE:
  - `out_valid = 1`.
  - `diff` is the result register and `borrow` is the final `br`; both are held stable.
  - On `out_valid & out_ready`, go to IDLE.
  - `in_ready` stays 0 in DONE, so the block does no accept-on-same-cycle pass-through.
- `in_valid` outside IDLE is ignored, and the operands are not sampled.
- `out_ready` outside DONE is ignored.
- The counter is `$clog2(WIDTH)` bits wide. It never wraps, because it is cleared on accept.
- Reset, at any time including mid-RUN:
  - Immediate return to IDLE.
  - All registers clear.
  - Outputs: `in_ready = 1`, `out_valid = 0`, `diff = 0`, `borrow = 0`, `busy = 0`.
  - Any partial result is discarded.

## Timing
- Accept edge = edge 0. RUN occupies edges 1..WIDTH. `out_valid` rises after edge WIDTH.
- Latency from the accept edge to `out_valid` is WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH run cycles, and one DONE cycle with `out_ready = 1`.
- `out_ready` held low stalls in DONE indefinitely, with no loss of data.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`out_ready` to any output.

## Configuration
- Macro `SERIAL_SUB_ADD_MODE_EN`.
- Defined:
  - Adds input port `op` (1 bit), sampled at accept: 0 = subtract, 1 = add.
  - In add mode:
    - `d = ai ^ bi ^ c`.
    - `c_next = (ai & bi) | ((ai ^ bi) & c)`.
    - `diff` carries the sum mod 2^WIDTH.
    - `borrow` carries the carry-out.
  - `op` is latched and ignored after accept.
- Undefined: port `op` is absent and the block is subtract only.

## Test plan
- WIDTH=8, a=0x05, b=0x03 -> after 8 cycles `diff = 0x02`, `borrow = 0`, `out_valid = 1`.
- a=0x03, b=0x05 -> `diff = 0xFE`, `borrow = 1`. Also a=0x00, b=0x01 -> `diff = 0xFF`, `borrow = 1`. Also a=b=0xA5 -> `diff = 0x00`, `borrow = 0`.
- Backpressure and busy behaviour:
  - Hold `out_ready = 0` for 5 cycles in DONE -> `diff`/`borrow`/`out_valid` stay constant and `in_ready = 0`.
  - Pulse `in_valid` with new operands during RUN -> they are ignored and the result is unchanged.
- Assert `rst_n = 0` at RUN cycle 4 -> outputs immediately reach their reset values. The next transaction, a=0x10, b=0x01, yields `diff = 0x0F` with no residue from the aborted one.
- Back-to-back: two transactions with `out_ready` tied high -> the second accept occurs exactly WIDTH+2 cycles after the first.
- With `SERIAL_SUB_ADD_MODE_EN`: op=1, a=0xFF, b=0x01 -> `diff = 0x00`, `borrow = 1`. Then op=0 on the same operands -> `diff = 0xFE`, `borrow = 0`.
